decode_seq: RTL and testbench

- Registered decode stage for the pipelined CPU, placed between fetch/IF-ID and the register-read/execute stages.
- Translates op/funct/rd into the same control bundle as the single-cycle decoder: reg_src, imm_src, alu_src, mem_to_reg, reg_w, mem_w, pcs, flag_w, alu_control.
- Adds valid/ready handshaking, flush, and a parametrised multi-cycle multiply hold.
- Adds a block-transfer op class (op=2'b11, LDM/STM-like), which is expanded into one micro-op per set register-list bit.

---
 rtl/decode_seq_pkg.sv | 61 ++++++
 rtl/decode_seq_reg_list_scan.sv | 24 ++
 rtl/decode_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_decode_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_seq_pkg.sv
// Shared encodings for the registered decode stage: op classes, ALU function
// codes, control vectors and the sequencer state type.
package decode_pkg;

   typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_BLOCK} state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_BLK = 2'b11;

   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_MUL = 4'b0001;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_ADD = 4'b0100;
   localparam logic [3:0] FN_ORR = 4'b1100;
   localparam logic [3:0] FN_XOR = 4'b1101;
   localparam logic [3:0] FN_CMP = 4'b1111;

   localparam logic [2:0] ALUC_AND   = 3'b000;
   localparam logic [2:0] ALUC_XOR   = 3'b001;
   localparam logic [2:0] ALUC_SUB   = 3'b010;
   localparam logic [2:0] ALUC_ADD   = 3'b011;
   localparam logic [2:0] ALUC_CMP   = 3'b100;
   localparam logic [2:0] ALUC_ORR   = 3'b101;
   localparam logic [2:0] ALUC_MUL   = 3'b110;
   localparam logic [2:0] ALUC_OTHER = 3'b111;

   typedef struct packed {
      logic [1:0] reg_src;
      logic [1:0] imm_src;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
   } ctrl_t;

   localparam ctrl_t CV_DP_IMM = 10'b0000101001;
   localparam ctrl_t CV_DP_REG = 10'b0000001001;
   localparam ctrl_t CV_LDR    = 10'b0001111000;
   localparam ctrl_t CV_STR    = 10'b1001110100;
   localparam ctrl_t CV_BR     = 10'b0110100010;

   localparam logic [3:0] PC_REG = 4'd15;

   function automatic logic [2:0] alu_decode(input logic [3:0] fn);
      case (fn)
         FN_ADD:  return ALUC_ADD;
         FN_SUB:  return ALUC_SUB;
         FN_AND:  return ALUC_AND;
         FN_ORR:  return ALUC_ORR;
         FN_XOR:  return ALUC_XOR;
         FN_MUL:  return ALUC_MUL;
         FN_CMP:  return ALUC_CMP;
         default: return ALUC_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/decode_seq_reg_list_scan.sv
// Combinational lowest-set-bit finder over a register list; also returns the
// list with that bit cleared.
module reg_list_scan #(
   parameter int unsigned LIST_W = 16
) (
   input  logic [LIST_W-1:0] mask,
   output logic [3:0]        index,
   output logic              found,
   output logic [LIST_W-1:0] rest
);

   always_comb begin
      index = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < LIST_W; i++) begin
         if (mask[i] && !found) begin
            index = 4'(i);
            found = 1'b1;
         end
      end
      rest = mask & (mask - LIST_W'(1));
   end

endmodule

// File: rtl/decode_seq.sv
// Registered decode stage with valid/ready handshake, flush, multi-cycle MUL
// hold and block-transfer expansion into one micro-op per register-list bit.
module decode_seq
   import decode_pkg::*;
#(
   parameter int unsigned LIST_W     = 16,
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned OFF_W      = 8,
   parameter int unsigned ALUC_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic [5:0]        funct,
   input  logic [3:0]        rd,
   input  logic [LIST_W-1:0] reg_list,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        reg_src,
   output logic [1:0]        imm_src,
   output logic              alu_src,
   output logic              mem_to_reg,
   output logic              reg_w,
   output logic              mem_w,
   output logic              pcs,
   output logic [1:0]        flag_w,
   output logic [ALUC_W-1:0] alu_control,
   output logic [3:0]        uop_rd,
   output logic [OFF_W-1:0]  uop_offset,
   output logic              uop_last,
   output logic              busy
);

   localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    mul_cnt_q, mul_cnt_d;
   logic [LIST_W-1:0]   mask_q, mask_d;
   logic [OFF_W-1:0]    k_q, k_d;
   logic                blk_load_q, blk_load_d;
   logic                out_valid_q, out_valid_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [2:0]          aluc_q, aluc_d;
   logic [1:0]          flag_q, flag_d;
   logic [3:0]          uop_rd_q, uop_rd_d;
   logic [OFF_W-1:0]    uop_offset_q, uop_offset_d;
   logic                uop_last_q, uop_last_d;

   ctrl_t               dec_ctrl, blk_ctrl;
   logic [2:0]          dec_aluc;
   logic [1:0]          dec_flag;
   logic                dec_is_mul, blk_ld, accept, fire;
   logic [LIST_W-1:0]   scan_in, scan_rest;
   logic [3:0]          scan_idx;
   logic                scan_found;

   // One scanner serves both the accepting edge (fresh list) and later micro-ops.
   assign scan_in = (state_q == S_BLOCK) ? mask_q : reg_list;

   reg_list_scan #(.LIST_W(LIST_W)) u_scan (
      .mask  (scan_in),
      .index (scan_idx),
      .found (scan_found),
      .rest  (scan_rest)
   );

   always_comb begin
      case (op)
         OP_DP:   dec_ctrl = funct[5] ? CV_DP_IMM : CV_DP_REG;
         OP_MEM:  dec_ctrl = funct[0] ? CV_LDR : CV_STR;
         OP_BR:   dec_ctrl = CV_BR;
         default: dec_ctrl = funct[0] ? CV_LDR : CV_STR;
      endcase
      if (dec_ctrl.alu_op) begin
         dec_aluc = alu_decode(funct[4:1]);
         dec_flag = {funct[0], funct[0] & ((funct[4:1] == FN_ADD) | (funct[4:1] == FN_SUB))};
      end else begin
         dec_aluc = ALUC_ADD;
         dec_flag = '0;
      end
      dec_is_mul = (op == OP_DP) && (funct[4:1] == FN_MUL);
      blk_ld     = (state_q == S_BLOCK) ? blk_load_q : funct[0];
      blk_ctrl   = blk_ld ? CV_LDR : CV_STR;
      if (!scan_found) begin
         blk_ctrl.reg_w = 1'b0;
         blk_ctrl.mem_w = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mul_cnt_q    <= '0;
         mask_q       <= '0;
         k_q          <= '0;
         blk_load_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         ctrl_q       <= '0;
         aluc_q       <= '0;
         flag_q       <= '0;
         uop_rd_q     <= '0;
         uop_offset_q <= '0;
         uop_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mul_cnt_q    <= mul_cnt_d;
         mask_q       <= mask_d;
         k_q          <= k_d;
         blk_load_q   <= blk_load_d;
         out_valid_q  <= out_valid_d;
         ctrl_q       <= ctrl_d;
         aluc_q       <= aluc_d;
         flag_q       <= flag_d;
         uop_rd_q     <= uop_rd_d;
         uop_offset_q <= uop_offset_d;
         uop_last_q   <= uop_last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mul_cnt_d    = mul_cnt_q;
      mask_d       = mask_q;
      k_d          = k_q;
      blk_load_d   = blk_load_q;
      out_valid_d  = out_valid_q;
      ctrl_d       = ctrl_q;
      aluc_d       = aluc_q;
      flag_d       = flag_q;
      uop_rd_d     = uop_rd_q;
      uop_offset_d = uop_offset_q;
      uop_last_d   = uop_last_q;
      accept       = in_valid & in_ready;
      fire         = out_valid_q & out_ready;
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         mul_cnt_d   = '0;
         mask_d      = '0;
         k_d         = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  out_valid_d  = 1'b1;
                  ctrl_d       = dec_ctrl;
                  aluc_d       = dec_aluc;
                  flag_d       = dec_flag;
                  uop_rd_d     = rd;
                  uop_offset_d = '0;
                  uop_last_d   = 1'b1;
                  if (op == OP_BLK) begin
                     // First micro-op issues on the accepting edge; mask keeps the rest.
                     ctrl_d     = blk_ctrl;
                     aluc_d     = ALUC_ADD;
                     flag_d     = '0;
                     uop_rd_d   = scan_found ? scan_idx : 4'd0;
                     uop_last_d = !scan_found || (scan_rest == '0);
                     mask_d     = scan_rest;
                     k_d        = OFF_W'(1);
                     blk_load_d = funct[0];
                     state_d    = S_BLOCK;
                  end else if (dec_is_mul && (MUL_CYCLES > 1)) begin
                     out_valid_d = 1'b0;
                     mul_cnt_d   = CNT_W'(MUL_CYCLES - 1);
                     state_d     = S_MUL_WAIT;
                  end
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
               end
            end
            S_MUL_WAIT: begin
               if (mul_cnt_q == CNT_W'(1)) begin
                  out_valid_d = 1'b1;
                  mul_cnt_d   = '0;
                  state_d     = S_IDLE;
               end else begin
                  mul_cnt_d = mul_cnt_q - CNT_W'(1);
               end
            end
            default: begin
               if (fire) begin
                  if (uop_last_q) begin
                     out_valid_d = 1'b0;
                     k_d         = '0;
                     state_d     = S_IDLE;
                  end else begin
                     ctrl_d       = blk_ctrl;
                     uop_rd_d     = scan_idx;
                     uop_offset_d = k_q << 2;
                     uop_last_d   = (scan_rest == '0);
                     mask_d       = scan_rest;
                     k_d          = k_q + OFF_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      in_ready    = !reset && !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);
      busy        = (state_q != S_IDLE);
      out_valid   = out_valid_q;
      reg_src     = ctrl_q.reg_src;
      imm_src     = ctrl_q.imm_src;
      alu_src     = ctrl_q.alu_src;
      mem_to_reg  = ctrl_q.mem_to_reg;
      reg_w       = ctrl_q.reg_w & out_valid_q;
      mem_w       = ctrl_q.mem_w & out_valid_q;
      pcs         = out_valid_q & (((uop_rd_q == PC_REG) & ctrl_q.reg_w) | ctrl_q.branch);
      flag_w      = out_valid_q ? flag_q : 2'b00;
      alu_control = ALUC_W'(aluc_q);
      uop_rd      = uop_rd_q;
      uop_offset  = uop_offset_q;
      uop_last    = uop_last_q;
   end

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: table of single-cycle decodes plus
// hand-written MUL, block-transfer, stall and flush sequences.
module tb_decode_seq;

   localparam int unsigned LIST_W     = 16;
   localparam int unsigned MUL_CYCLES = 3;
   localparam int unsigned OFF_W      = 8;
   localparam int unsigned ALUC_W     = 3;

   typedef struct packed {
      logic [1:0] reg_src;
      logic [1:0] imm_src;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_w;
      logic       mem_w;
      logic       pcs;
      logic [1:0] flag_w;
      logic [2:0] aluc;
      logic [3:0] rd;
      logic [7:0] off;
      logic       last;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      exp_t       exp;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [1:0]        op, reg_src, imm_src, flag_w;
   logic [5:0]        funct;
   logic [3:0]        rd, uop_rd;
   logic [LIST_W-1:0] reg_list;
   logic              alu_src, mem_to_reg, reg_w, mem_w, pcs, uop_last, busy;
   logic [ALUC_W-1:0] alu_control;
   logic [OFF_W-1:0]  uop_offset;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   n_out = 0;
   exp_t sb[$];
   exp_t pend[$];
   vec_t vecs[13];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   decode_seq #(
      .LIST_W(LIST_W), .MUL_CYCLES(MUL_CYCLES), .OFF_W(OFF_W), .ALUC_W(ALUC_W)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct(funct), .rd(rd), .reg_list(reg_list), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .reg_src(reg_src),
      .imm_src(imm_src), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_w(reg_w), .mem_w(mem_w), .pcs(pcs), .flag_w(flag_w),
      .alu_control(alu_control), .uop_rd(uop_rd), .uop_offset(uop_offset),
      .uop_last(uop_last), .busy(busy)
   );

   function automatic exp_t mk(input int rs, input int ims, input int as, input int m2r,
                               input int rw, input int mw, input int pc, input int fw,
                               input int ac, input int r, input int off, input int last);
      exp_t e;
      e.reg_src    = 2'(rs);
      e.imm_src    = 2'(ims);
      e.alu_src    = 1'(as);
      e.mem_to_reg = 1'(m2r);
      e.reg_w      = 1'(rw);
      e.mem_w      = 1'(mw);
      e.pcs        = 1'(pc);
      e.flag_w     = 2'(fw);
      e.aluc       = 3'(ac);
      e.rd         = 4'(r);
      e.off        = 8'(off);
      e.last       = 1'(last);
      return e;
   endfunction

   function automatic exp_t act_bundle();
      return {reg_src, imm_src, alu_src, mem_to_reg, reg_w, mem_w, pcs, flag_w,
              alu_control, uop_rd, uop_offset, uop_last};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: every completed transfer is compared with the oldest expectation.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%h required=no_output", act_bundle());
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("uop_%0d", n_out), 32'(act_bundle()), 32'(e));
         end
         n_out++;
      end
   end

   task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                        input logic [15:0] l, output int acc_cyc);
      bit done;
      done     = 1'b0;
      acc_cyc  = -1;
      op       = o;
      funct    = f;
      rd       = r;
      reg_list = l;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            done    = 1'b1;
            acc_cyc = cyc + 1;
            while (pend.size() > 0) sb.push_back(pend.pop_front());
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=not_accepted required=accepted");
         pend.delete();
      end
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while ((sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) && i < 60) begin
         @(negedge clk);
         i++;
      end
      check({name, "_drain"}, 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   acc, acc2, rel;
      exp_t b_exp;
      logic [31:0] snap;

      vecs[0]  = '{2'b00, 6'b101001, 4'd3,  mk(0,0,1,0,1,0,0,3,3'b011,3,0,1)};
      vecs[1]  = '{2'b00, 6'b000100, 4'd5,  mk(0,0,0,0,1,0,0,0,3'b010,5,0,1)};
      vecs[2]  = '{2'b00, 6'b000101, 4'd4,  mk(0,0,0,0,1,0,0,3,3'b010,4,0,1)};
      vecs[3]  = '{2'b00, 6'b100001, 4'd2,  mk(0,0,1,0,1,0,0,2,3'b000,2,0,1)};
      vecs[4]  = '{2'b00, 6'b011000, 4'd7,  mk(0,0,0,0,1,0,0,0,3'b101,7,0,1)};
      vecs[5]  = '{2'b00, 6'b111011, 4'd1,  mk(0,0,1,0,1,0,0,2,3'b001,1,0,1)};
      vecs[6]  = '{2'b00, 6'b011111, 4'd0,  mk(0,0,0,0,1,0,0,2,3'b100,0,0,1)};
      vecs[7]  = '{2'b00, 6'b001110, 4'd6,  mk(0,0,0,0,1,0,0,0,3'b111,6,0,1)};
      vecs[8]  = '{2'b00, 6'b001000, 4'd15, mk(0,0,0,0,1,0,1,0,3'b011,15,0,1)};
      vecs[9]  = '{2'b01, 6'b000001, 4'd9,  mk(0,1,1,1,1,0,0,0,3'b011,9,0,1)};
      vecs[10] = '{2'b01, 6'b000001, 4'd15, mk(0,1,1,1,1,0,1,0,3'b011,15,0,1)};
      vecs[11] = '{2'b01, 6'b000000, 4'd15, mk(2,1,1,1,0,1,0,0,3'b011,15,0,1)};
      vecs[12] = '{2'b10, 6'b010101, 4'd2,  mk(1,2,1,0,0,0,1,0,3'b011,2,0,1)};
      b_exp    = vecs[12].exp;

      reset     = 1'b1;
      in_valid  = 1'b1;
      op        = 2'b00;
      funct     = 6'b101001;
      rd        = 4'd3;
      reg_list  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_bundle", 32'(act_bundle()), 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      rel   = cyc;

      for (int i = 0; i < 13; i++) begin
         pend.push_back(vecs[i].exp);
         issue(vecs[i].op, vecs[i].funct, vecs[i].rd, 16'h0000, acc);
         if (i == 0) check("first_accept_cycle", 32'(acc), 32'(rel + 1));
      end
      wait_drain("table");

      // MUL holds the stage for MUL_CYCLES edges after acceptance
      pend.push_back(mk(0,0,0,0,1,0,0,0,3'b110,8,0,1));
      issue(2'b00, 6'b000010, 4'd8, 16'h0000, acc);
      repeat (2) begin
         @(negedge clk);
         check("mul_busy", 32'(busy), 32'd1);
         check("mul_in_ready", 32'(in_ready), 32'd0);
         check("mul_out_valid", 32'(out_valid), 32'd0);
         check("mul_reg_w_gated", 32'(reg_w), 32'd0);
      end
      @(negedge clk);
      check("mul_valid_edge3", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      wait_drain("mul");

      // LDM {r0,r2,r15} with the second micro-op stalled for two cycles
      pend.push_back(mk(0,1,1,1,1,0,0,0,3'b011,0,0,0));
      pend.push_back(mk(0,1,1,1,1,0,0,0,3'b011,2,4,0));
      pend.push_back(mk(0,1,1,1,1,0,1,0,3'b011,15,8,1));
      issue(2'b11, 6'b000001, 4'd0, 16'h8005, acc);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("ldm_stall_rd", 32'(uop_rd), 32'd2);
      check("ldm_stall_busy", 32'(busy), 32'd1);
      check("ldm_stall_in_ready", 32'(in_ready), 32'd0);
      snap = {out_valid, busy, 3'b000, act_bundle()};
      @(negedge clk);
      check("ldm_hold", {out_valid, busy, 3'b000, act_bundle()}, snap);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain("ldm");

      // STM {r1,r2,r4,r5} flushed while its second micro-op is presented
      pend.push_back(mk(2,1,1,1,0,1,0,0,3'b011,1,0,0));
      issue(2'b11, 6'b000000, 4'd0, 16'h0036, acc);
      @(posedge clk);
      #1;
      flush     = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op        = 2'b10;
      funct     = 6'b010101;
      rd        = 4'd2;
      reg_list  = '0;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      check("stm_second_rd", 32'(uop_rd), 32'd2);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      out_ready = 1'b1;
      pend.push_back(b_exp);
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      check("post_flush_in_ready", 32'(in_ready), 32'd1);
      if (in_ready === 1'b1) begin
         while (pend.size() > 0) sb.push_back(pend.pop_front());
      end else begin
         pend.delete();
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_drain("flush");

      // Empty register list, then a branch right behind it
      pend.push_back(mk(0,1,1,1,0,0,0,0,3'b011,0,0,1));
      issue(2'b11, 6'b000001, 4'd0, 16'h0000, acc);
      pend.push_back(b_exp);
      issue(2'b10, 6'b010101, 4'd2, 16'h0000, acc2);
      check("empty_then_b_cycle", 32'(acc2), 32'(acc + 2));
      wait_drain("empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
